// File: rtl/md_unit_pkg.sv
// -----------------------------------------------------------------------------
// md_unit_pkg
// Shared definitions for the E-stage multiply/divide unit: op encodings
// (also used by the controller, pipeline registers and hazard unit), the
// counter FSM state type and op classification helpers.
//
// Optional feature macro: MD_UNIT_MADD_EN (op 7 becomes MADD when defined).
// -----------------------------------------------------------------------------
package md_unit_pkg;

    localparam int MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_NOP   = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;
    localparam logic [MD_OP_W-1:0] MD_MADD  = 3'd7;

    // IDLE: ready to accept; RUN: multi-cycle op in flight (busy).
    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the unit for several cycles.
    function automatic logic md_is_long(input logic [MD_OP_W-1:0] op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MD_UNIT_MADD_EN
            MD_MADD: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Ops that would change unit state if accepted.
    function automatic logic md_has_effect(input logic [MD_OP_W-1:0] op);
        return md_is_long(op) || (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// -----------------------------------------------------------------------------
// md_unit_if
// Bundle between the E-stage pipeline and the multiply/divide unit.
//   md_op     : op from the E-stage register
//   cancel    : E-stage instruction squashed, blocks any new op this cycle
//   a, b      : forwarded RS / RT values
//   hi, lo    : current HI / LO
//   busy      : multi-cycle op in flight (registered)
//   active    : busy, or a long op presented and not cancelled (combinational)
//   dbg_state : FSM state, for observation only
//
// Handshake: there is no ready; the hazard unit stalls any md instruction
// while active is high, so an op is consumed on the edge it is presented
// whenever the unit is idle and cancel is low. Ops presented while busy are
// dropped.
// -----------------------------------------------------------------------------
interface md_unit_if;
    import md_unit_pkg::*;

    logic [MD_OP_W-1:0] md_op;
    logic               cancel;
    logic [31:0]        a;
    logic [31:0]        b;
    logic [31:0]        hi;
    logic [31:0]        lo;
    logic               busy;
    logic               active;
    md_state_e          dbg_state;

    modport master (
        output md_op, cancel, a, b,
        input  hi, lo, busy, active, dbg_state
    );

    modport slave (
        input  md_op, cancel, a, b,
        output hi, lo, busy, active, dbg_state
    );

endinterface

// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
// E-stage multiply/divide unit. Owns HI/LO and emulates the fixed latency of
// MULT/DIV: the full result is computed when the op is accepted, parked in
// hi_tmp/lo_tmp, and written to HI/LO exactly N cycles later.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low; clears HI/LO, FSM, counter, pending result
//   md    : md_unit_if.slave (md_op, cancel, a, b -> hi, lo, busy, active)
//
// Parameters:
//   MULT_CYCLES : busy cycles for MULT/MULTU/MADD (>=1)
//   DIV_CYCLES  : busy cycles for DIV/DIVU (>=1)
//
// Optional feature macro: MD_UNIT_MADD_EN enables op 7 as
//   {hi,lo} <= {hi,lo} + signed(a)*signed(b); otherwise op 7 is a NOP.
// -----------------------------------------------------------------------------
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   md
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_e          r_state;
    md_state_e          w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_hi_tmp;
    logic [31:0]        r_lo_tmp;
    logic               r_tmp_wr;

    logic               w_idle_ok;
    logic               w_accept;
    logic               w_commit;
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic signed [31:0] w_a_s;
    logic signed [31:0] w_b_s;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_res_wr;
    logic [CNT_W-1:0]   w_load;

    assign w_idle_ok = (r_state == MD_IDLE) && !md.cancel;
    assign w_accept  = w_idle_ok && md_is_long(md.md_op);
    assign w_commit  = (r_state == MD_RUN) && (r_cnt == CNT_ONE);

    assign w_a_s    = $signed(md.a);
    assign w_b_s    = $signed(md.b);
    assign w_prod_s = $signed({{32{md.a[31]}}, md.a}) * $signed({{32{md.b[31]}}, md.b});
    assign w_prod_u = {32'd0, md.a} * {32'd0, md.b};

    // Result that would be parked in hi_tmp/lo_tmp if the current op is accepted.
    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        w_res_wr = 1'b1;
        w_load   = MULT_LOAD;
        case (md.md_op)
            MD_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            MD_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            MD_DIV: begin
                w_load = DIV_LOAD;
                if (md.b == 32'd0) begin
                    // Divide by zero still costs the full latency but leaves HI/LO alone.
                    w_res_wr = 1'b0;
                end else if ((md.a == 32'h8000_0000) && (md.b == 32'hFFFF_FFFF)) begin
                    // Only signed quotient that overflows; pin it rather than rely on the operator.
                    w_res_lo = 32'h8000_0000;
                    w_res_hi = 32'd0;
                end else begin
                    w_res_lo = w_a_s / w_b_s;
                    w_res_hi = w_a_s % w_b_s;
                end
            end
            MD_DIVU: begin
                w_load = DIV_LOAD;
                if (md.b == 32'd0) begin
                    w_res_wr = 1'b0;
                end else begin
                    w_res_lo = md.a / md.b;
                    w_res_hi = md.a % md.b;
                end
            end
`ifdef MD_UNIT_MADD_EN
            MD_MADD:  {w_res_hi, w_res_lo} = {r_hi, r_lo} + w_prod_s;
`endif
            default: ;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: if (w_accept) w_state_nxt = MD_RUN;
            MD_RUN:  if (r_cnt == CNT_ONE) w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= MD_IDLE;
            r_cnt    <= '0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_hi_tmp <= 32'd0;
            r_lo_tmp <= 32'd0;
            r_tmp_wr <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_cnt    <= w_load;
                r_hi_tmp <= w_res_hi;
                r_lo_tmp <= w_res_lo;
                r_tmp_wr <= w_res_wr;
            end else if (r_state == MD_RUN) begin
                r_cnt <= r_cnt - CNT_ONE;
            end

            // Commit only happens in RUN and MTHI/MTLO only in IDLE, so they never collide.
            if (w_commit && r_tmp_wr) begin
                r_hi <= r_hi_tmp;
                r_lo <= r_lo_tmp;
            end else begin
                if (w_idle_ok && (md.md_op == MD_MTHI)) r_hi <= md.a;
                if (w_idle_ok && (md.md_op == MD_MTLO)) r_lo <= md.a;
            end
        end
    end

    assign md.hi        = r_hi;
    assign md.lo        = r_lo;
    assign md.busy      = (r_state == MD_RUN);
    assign md.active    = (r_state == MD_RUN) || (md_is_long(md.md_op) && !md.cancel);
    assign md.dbg_state = r_state;

    // The hazard unit is expected to hold md ops back while busy; one getting
    // through is dropped here, so flag it in simulation.
    always @(posedge clk) begin
        if (reset && (r_state == MD_RUN) && !md.cancel) begin
            assert (!md_has_effect(md.md_op))
                else $warning("md_unit: op %0d dropped while busy", md.md_op);
        end
    end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
    import md_unit_pkg::*;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    md_unit_if bus ();

    md_unit u_dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input logic cn);
        bus.md_op  = op;
        bus.a      = av;
        bus.b      = bv;
        bus.cancel = cn;
    endtask

    // Present op for one edge, then count cycles busy stays high (bounded).
    task automatic exec(input logic [2:0] op, input logic [31:0] av,
                        input logic [31:0] bv, output int n_busy);
        drive(op, av, bv, 1'b0);
        tick();
        drive(MD_NOP, 32'd0, 32'd0, 1'b0);
        n_busy = 0;
        while (bus.busy && n_busy < 40) begin
            n_busy++;
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        reset = 1'b0;
        drive(MD_NOP, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        n_total++; if (bus.hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi: got %h want %h", bus.hi, 32'd0); end
        n_total++; if (bus.lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo: got %h want %h", bus.lo, 32'd0); end
        n_total++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        reset = 1'b1;
        tick();
        // MULT 3*4 in flight, then reset for 2 cycles mid-operation.
        drive(MD_MULT, 32'd3, 32'd4, 1'b0);
        tick();
        drive(MD_NOP, 32'd0, 32'd0, 1'b0);
        n_total++; if (bus.dbg_state !== MD_RUN) begin n_bad++; $display("FAIL reset_run_state: got %0d want %0d", bus.dbg_state, MD_RUN); end
        tick();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        n_total++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid_busy: got %b want 0", bus.busy); end
        n = 0;
        repeat (8) begin
            tick();
            if (bus.lo !== 32'd0 || bus.busy !== 1'b0) n++;
        end
        n_total++; if (n !== 0) begin n_bad++; $display("FAIL reset_no_commit: got %0d bad cycles want 0 (lo=%h)", n, bus.lo); end
    endtask

    task automatic test_mult();
        int n;
        drive(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        tick();
        drive(MD_NOP, 32'd0, 32'd0, 1'b0);
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            if (n == 5) begin
                n_total++; if (bus.lo !== 32'd0) begin n_bad++; $display("FAIL mult_early: got lo=%h want %h", bus.lo, 32'd0); end
            end
            tick();
        end
        n_total++; if (n !== 5) begin n_bad++; $display("FAIL mult_busy_cycles: got %0d want 5", n); end
        n_total++; if (bus.hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi: got %h want %h", bus.hi, 32'hFFFF_FFFF); end
        n_total++; if (bus.lo !== 32'hFFFF_FFFA) begin n_bad++; $display("FAIL mult_lo: got %h want %h", bus.lo, 32'hFFFF_FFFA); end
        exec(MD_MULTU, 32'hFFFF_FFFE, 32'd3, n);
        n_total++; if (n !== 5) begin n_bad++; $display("FAIL multu_busy_cycles: got %0d want 5", n); end
        n_total++; if (bus.hi !== 32'h0000_0002) begin n_bad++; $display("FAIL multu_hi: got %h want %h", bus.hi, 32'h2); end
        n_total++; if (bus.lo !== 32'hFFFF_FFFA) begin n_bad++; $display("FAIL multu_lo: got %h want %h", bus.lo, 32'hFFFF_FFFA); end
    endtask

    task automatic test_div();
        int n;
        exec(MD_DIV, 32'hFFFF_FFF9, 32'd2, n); // -7 / 2
        n_total++; if (n !== 10) begin n_bad++; $display("FAIL div_busy_cycles: got %0d want 10", n); end
        n_total++; if (bus.lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo: got %h want %h", bus.lo, 32'hFFFF_FFFD); end
        n_total++; if (bus.hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi: got %h want %h", bus.hi, 32'hFFFF_FFFF); end
        exec(MD_DIVU, 32'd7, 32'd0, n);
        n_total++; if (n !== 10) begin n_bad++; $display("FAIL divu0_busy_cycles: got %0d want 10", n); end
        n_total++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_bad++; $display("FAIL divu0_unchanged: got %h want %h", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD); end
        exec(MD_DIV, 32'd7, 32'hFFFF_FFFE, n); // 7 / -2 = -3 rem 1
        n_total++; if ({bus.hi, bus.lo} !== 64'h0000_0001_FFFF_FFFD) begin n_bad++; $display("FAIL div_negdivisor: got %h want %h", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFD); end
        exec(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        n_total++; if ({bus.hi, bus.lo} !== 64'h0000_0000_8000_0000) begin n_bad++; $display("FAIL div_overflow: got %h want %h", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000); end
        exec(MD_DIVU, 32'hFFFF_FFFF, 32'd2, n);
        n_total++; if ({bus.hi, bus.lo} !== 64'h0000_0001_7FFF_FFFF) begin n_bad++; $display("FAIL divu: got %h want %h", {bus.hi, bus.lo}, 64'h0000_0001_7FFF_FFFF); end
        exec(MD_DIV, 32'd5, 32'd0, n);
        n_total++; if ({bus.hi, bus.lo} !== 64'h0000_0001_7FFF_FFFF) begin n_bad++; $display("FAIL div0_unchanged: got %h want %h", {bus.hi, bus.lo}, 64'h0000_0001_7FFF_FFFF); end
    endtask

    task automatic test_mt();
        int n;
        exec(MD_MTHI, 32'h1234_5678, 32'd0, n);
        n_total++; if (bus.hi !== 32'h1234_5678) begin n_bad++; $display("FAIL mthi: got %h want %h", bus.hi, 32'h1234_5678); end
        n_total++; if (n !== 0) begin n_bad++; $display("FAIL mthi_busy: got %0d busy cycles want 0", n); end
        exec(MD_MTLO, 32'hCAFE_F00D, 32'd0, n);
        n_total++; if (bus.lo !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL mtlo: got %h want %h", bus.lo, 32'hCAFE_F00D); end
        // MTLO presented while a MULT 2*3 is running must be dropped.
        drive(MD_MULT, 32'd2, 32'd3, 1'b0);
        tick();
        drive(MD_NOP, 32'd0, 32'd0, 1'b0);
        tick();
        drive(MD_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0);
        n_total++; if (bus.active !== 1'b1) begin n_bad++; $display("FAIL active_busy: got %b want 1", bus.active); end
        tick();
        drive(MD_NOP, 32'd0, 32'd0, 1'b0);
        n_total++; if (bus.lo !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL mtlo_busy_ignored: got %h want %h", bus.lo, 32'hCAFE_F00D); end
        n = 0;
        while (bus.busy && n < 40) begin n++; tick(); end
        n_total++; if ({bus.hi, bus.lo} !== 64'h0000_0000_0000_0006) begin n_bad++; $display("FAIL mult_after_mtlo: got %h want %h", {bus.hi, bus.lo}, 64'h6); end
    endtask

    task automatic test_cancel();
        int n;
        exec(MD_MTHI, 32'h1111_1111, 32'd0, n);
        exec(MD_MTLO, 32'h2222_2222, 32'd0, n);
        drive(MD_DIV, 32'd10, 32'd3, 1'b0);
        #1;
        n_total++; if (bus.active !== 1'b1) begin n_bad++; $display("FAIL active_comb: got %b want 1", bus.active); end
        drive(MD_DIV, 32'd10, 32'd3, 1'b1);
        #1;
        n_total++; if (bus.active !== 1'b0) begin n_bad++; $display("FAIL active_cancel: got %b want 0", bus.active); end
        tick();
        n_total++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL cancel_busy: got %b want 0", bus.busy); end
        drive(MD_MTHI, 32'h3333_3333, 32'd0, 1'b1);
        tick();
        drive(MD_MTHI, 32'h3333_3333, 32'd0, 1'b0);
        #1;
        n_total++; if (bus.active !== 1'b0) begin n_bad++; $display("FAIL active_mthi: got %b want 0", bus.active); end
        drive(MD_NOP, 32'd0, 32'd0, 1'b0);
        tick();
        n_total++; if ({bus.hi, bus.lo} !== 64'h1111_1111_2222_2222) begin n_bad++; $display("FAIL cancel_unchanged: got %h want %h", {bus.hi, bus.lo}, 64'h1111_1111_2222_2222); end
        // Cancel held high through RUN does not abort the accepted DIV 10/3.
        drive(MD_DIV, 32'd10, 32'd3, 1'b0);
        tick();
        drive(MD_NOP, 32'd0, 32'd0, 1'b1);
        n = 0;
        while (bus.busy && n < 40) begin n++; tick(); end
        bus.cancel = 1'b0;
        n_total++; if (n !== 10) begin n_bad++; $display("FAIL cancel_run_cycles: got %0d want 10", n); end
        n_total++; if ({bus.hi, bus.lo} !== 64'h0000_0001_0000_0003) begin n_bad++; $display("FAIL cancel_run_commit: got %h want %h", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003); end
    endtask

    task automatic test_madd();
        int n;
        exec(MD_MTHI, 32'd0, 32'd0, n);
        exec(MD_MTLO, 32'hFFFF_FFFF, 32'd0, n);
        drive(MD_MADD, 32'd1, 32'd1, 1'b0);
        #1;
`ifdef MD_UNIT_MADD_EN
        n_total++; if (bus.active !== 1'b1) begin n_bad++; $display("FAIL madd_active: got %b want 1", bus.active); end
`else
        n_total++; if (bus.active !== 1'b0) begin n_bad++; $display("FAIL madd_active: got %b want 0", bus.active); end
`endif
        exec(MD_MADD, 32'd1, 32'd1, n);
`ifdef MD_UNIT_MADD_EN
        n_total++; if (n !== 5) begin n_bad++; $display("FAIL madd_cycles: got %0d want 5", n); end
        n_total++; if ({bus.hi, bus.lo} !== 64'h0000_0001_0000_0000) begin n_bad++; $display("FAIL madd_result: got %h want %h", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000); end
`else
        n_total++; if (n !== 0) begin n_bad++; $display("FAIL madd_cycles: got %0d want 0", n); end
        n_total++; if ({bus.hi, bus.lo} !== 64'h0000_0000_FFFF_FFFF) begin n_bad++; $display("FAIL madd_result: got %h want %h", {bus.hi, bus.lo}, 64'h0000_0000_FFFF_FFFF); end
`endif
    endtask

    task automatic test_back_to_back();
        int n;
        // MULTU presented on the commit edge of MULT 4*5 is dropped.
        drive(MD_MULT, 32'd4, 32'd5, 1'b0);
        tick();
        drive(MD_NOP, 32'd0, 32'd0, 1'b0);
        repeat (4) tick();
        drive(MD_MULTU, 32'd1, 32'd1, 1'b0);
        tick();
        drive(MD_NOP, 32'd0, 32'd0, 1'b0);
        n_total++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_dropped_busy: got %b want 0", bus.busy); end
        n_total++; if ({bus.hi, bus.lo} !== 64'd20) begin n_bad++; $display("FAIL b2b_mult: got %h want %h", {bus.hi, bus.lo}, 64'd20); end
        tick();
        n_total++; if ({bus.hi, bus.lo} !== 64'd20) begin n_bad++; $display("FAIL b2b_no_late: got %h want %h", {bus.hi, bus.lo}, 64'd20); end
        exec(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        n_total++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFE_0000_0001) begin n_bad++; $display("FAIL b2b_multu: got %h want %h", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001); end
        exec(MD_DIVU, 32'd100, 32'd7, n);
        n_total++; if (n !== 10) begin n_bad++; $display("FAIL b2b_divu_cycles: got %0d want 10", n); end
        n_total++; if ({bus.hi, bus.lo} !== 64'h0000_0002_0000_000E) begin n_bad++; $display("FAIL b2b_divu: got %h want %h", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_total = 0;
        n_bad   = 0;
        test_reset();
        test_mult();
        test_div();
        test_mt();
        test_cancel();
        test_madd();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
